axi_mem_responder: RTL and testbench

- AXI4 (subset) slave endpoint that terminates the single master port of the SpMV AXI switch.
- Backs a local register-array memory for vector and scratch data.
- Serves INCR bursts on independent write (AW/W/B) and read (AR/R) channels, with the same reduced signal set the switch carries.
- Used as an on-chip target for kernel buffers and as the bench target for switch tests.

---
 rtl/axi_mem_responder_pkg.sv | 27 ++
 rtl/axi_mem_array.sv | 34 +++
 rtl/axi_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_axi_mem_responder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_responder_pkg.sv
// Shared AXI response codes, channel FSM encodings and a ceil-log2 helper
// for the AXI memory responder and its storage array.
package axi_mem_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Byte-enabled register array: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after wr_en; read is same-cycle (old data on a same-word write).
// Backpressure: none, always accepts.
module axi_mem_array
    import axi_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [clog2(DEPTH)-1:0]    wr_idx,
    input  logic [DATA_WIDTH-1:0]      wr_dat,
    input  logic [DATA_WIDTH/8-1:0]    wr_strb,
    input  logic [clog2(DEPTH)-1:0]    rd_idx,
    output logic [DATA_WIDTH-1:0]      rd_dat
);

    // Contents are deliberately not reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4-subset INCR-burst slave backed by a local register array, one outstanding burst per channel.
// Latency: B one cycle after the last W beat; first R beat one cycle after AR, then 1 beat/cycle.
// Backpressure: R data/resp/last held while rready=0; B held until bready; AW/AR blocked while busy.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024
) (
    input  logic                      s_aclk,
    input  logic                      s_aresetn,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int LSB       = clog2(DATA_WIDTH/8);
    localparam int IW        = clog2(DEPTH);
    localparam int OOR_SHIFT = LSB + IW;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;
    logic      out_en;

    logic [IW-1:0] w_idx, r_idx, aw_idx, ar_idx, mem_rd_idx;
    logic [7:0]    w_len, w_cnt, r_len, r_cnt;
    logic          w_oor, w_err, r_oor;
    logic          aw_hs, w_hs, ar_hs, r_hs, w_final, ar_oor;
    logic [DATA_WIDTH-1:0] mem_rd_dat;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> OOR_SHIFT) != '0;
    endfunction

    assign aw_idx  = s_axi_awaddr[LSB +: IW];
    assign ar_idx  = s_axi_araddr[LSB +: IW];
    assign ar_oor  = out_of_range(s_axi_araddr);
    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign r_hs    = s_axi_rvalid && s_axi_rready;
    assign w_final = (w_cnt == w_len);

    // out_en keeps awready/arready low while reset is asserted.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
            out_en   <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            out_en   <= 1'b1;
        end
    end

    always_comb begin
        wr_state_nxt  = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        case (wr_state)
            W_IDLE: begin
                s_axi_awready = out_en;
                if (s_axi_awvalid && out_en) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_final) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = (w_oor || w_err) ? RESP_SLVERR : RESP_OKAY;
                if (s_axi_bready) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_nxt  = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi_arready = out_en;
                if (s_axi_arvalid && out_en) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && s_axi_rlast) rd_state_nxt = R_IDLE;
            end
        endcase
    end

    // Burst length is set by awlen; a wlast disagreement only flags the response.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            w_idx <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_oor <= 1'b0;
            w_err <= 1'b0;
        end else if (aw_hs) begin
            w_idx <= aw_idx;
            w_len <= s_axi_awlen;
            w_cnt <= '0;
            w_oor <= out_of_range(s_axi_awaddr);
            w_err <= 1'b0;
        end else if (w_hs) begin
            w_idx <= w_idx + IW'(1);
            w_cnt <= w_cnt + 8'd1;
            if (s_axi_wlast != w_final) w_err <= 1'b1;
        end
    end

    // Read port addresses the AR start while idle, then the prefetch index.
    assign mem_rd_idx = (rd_state == R_IDLE) ? ar_idx : r_idx;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_idx       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_oor       <= 1'b0;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
            s_axi_rlast <= 1'b0;
        end else if (ar_hs) begin
            r_idx       <= ar_idx + IW'(1);
            r_len       <= s_axi_arlen;
            r_cnt       <= '0;
            r_oor       <= ar_oor;
            s_axi_rdata <= ar_oor ? '0 : mem_rd_dat;
            s_axi_rresp <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            s_axi_rlast <= (s_axi_arlen == 8'd0);
        end else if (r_hs && !s_axi_rlast) begin
            r_idx       <= r_idx + IW'(1);
            r_cnt       <= r_cnt + 8'd1;
            s_axi_rdata <= r_oor ? '0 : mem_rd_dat;
            s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
        end
    end

    axi_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (s_aclk),
        .wr_en   (w_hs && !w_oor),
        .wr_idx  (w_idx),
        .wr_dat  (s_axi_wdata),
        .wr_strb (s_axi_wstrb),
        .rd_idx  (mem_rd_idx),
        .rd_dat  (mem_rd_dat)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomised + directed bench for axi_mem_responder against a word-array/queue reference model.
module tb_axi_mem_responder;

    localparam int DEPTH = 1024;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 8);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 clk = ~clk;

    axi_mem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .DEPTH      (DEPTH)
    ) dut (
        .s_aclk        (clk),
        .s_aresetn     (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Reference state: memory words, expected read beats, outstanding write burst.
    logic [63:0] model [DEPTH];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic        wl [256];
    bit          w_busy = 1'b0, b_pend = 1'b0, w_oor_m = 1'b0, w_err_m = 1'b0, r_busy = 1'b0;
    int          w_beat = 0, w_len_m = 0, w_ix = 0;
    logic [1:0]  b_exp = 2'b00;
    logic [1:0]  last_bresp = 2'b11;
    logic [63:0] rq_dat [$];
    logic [1:0]  rq_resp [$];
    logic        rq_last [$];
    logic [63:0] rd_log [$];
    logic [1:0]  rresp_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake, expected one within the cycle budget (t=%0t)", name, $time);
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'd8) % DEPTH);
    endfunction

    function automatic bit oor_of(input logic [31:0] a);
        return a >= MEM_BYTES;
    endfunction

    // Compare process: mid-cycle, outputs are settled and inputs are stable for the next edge.
    always @(negedge clk) begin
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, fin;
        int base;
        if (!rst_n) begin
            w_busy = 0; b_pend = 0; r_busy = 0;
            rq_dat.delete(); rq_resp.delete(); rq_last.delete();
        end else if (mon_on) begin
            chk("awready", awready, !w_busy);
            chk("wready", wready, w_busy && !b_pend);
            chk("bvalid", bvalid, b_pend);
            if (b_pend) chk("bresp", bresp, b_exp);
            chk("arready", arready, !r_busy);
            chk("rvalid", rvalid, r_busy);
            if (r_busy && rq_dat.size() > 0) begin
                chk("rdata", rdata, rq_dat[0]);
                chk("rresp", rresp, rq_resp[0]);
                chk("rlast", rlast, rq_last[0]);
            end
            aw_hs = awvalid && !w_busy;
            w_hs  = wvalid && w_busy && !b_pend;
            b_hs  = bready && b_pend;
            ar_hs = arvalid && !r_busy;
            r_hs  = rready && r_busy;
            if (r_hs) begin
                rd_log.push_back(rdata);
                rresp_log.push_back(rresp);
                if (rq_dat.size() > 0) begin
                    fin = rq_last[0];
                    void'(rq_dat.pop_front()); void'(rq_resp.pop_front()); void'(rq_last.pop_front());
                    if (fin) r_busy = 0;
                end else r_busy = 0;
            end
            // Reads snapshot memory before this cycle's write lands.
            if (ar_hs) begin
                base = idx_of(araddr);
                for (int k = 0; k <= int'(arlen); k++) begin
                    rq_dat.push_back(oor_of(araddr) ? 64'd0 : model[(base + k) % DEPTH]);
                    rq_resp.push_back(oor_of(araddr) ? 2'b10 : 2'b00);
                    rq_last.push_back(k == int'(arlen));
                end
                r_busy = 1;
            end
            if (b_hs) begin
                last_bresp = bresp;
                w_busy = 0;
                b_pend = 0;
            end
            if (w_hs) begin
                if (!w_oor_m)
                    for (int b = 0; b < 8; b++)
                        if (wstrb[b]) model[w_ix][b*8 +: 8] = wdata[b*8 +: 8];
                if (wlast != (w_beat == w_len_m)) w_err_m = 1;
                if (w_beat == w_len_m) begin
                    b_pend = 1;
                    b_exp = (w_oor_m || w_err_m) ? 2'b10 : 2'b00;
                end
                w_beat++;
                w_ix = (w_ix + 1) % DEPTH;
            end
            if (aw_hs) begin
                w_busy = 1; w_ix = idx_of(awaddr); w_len_m = int'(awlen);
                w_beat = 0; w_oor_m = oor_of(awaddr); w_err_m = 0;
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input int len, input bit hold_b, output int stalls);
        int g;
        bit done;
        stalls = 0;
        @(posedge clk); #1;
        awaddr = addr; awlen = 8'(len); awvalid = 1;
        g = 0;
        @(negedge clk);
        while (!awready && g < 200) begin g++; @(negedge clk); end
        if (g >= 200) timeout("aw_handshake");
        @(posedge clk); #1;
        awvalid = 0;
        for (int k = 0; k <= len; k++) begin
            wdata = wd[k]; wstrb = ws[k]; wlast = wl[k]; wvalid = 1;
            g = 0;
            @(negedge clk);
            while (!wready && g < 200) begin g++; stalls++; @(negedge clk); end
            @(posedge clk); #1;
            if (g >= 200) begin timeout("w_handshake"); break; end
        end
        wvalid = 0; wlast = 0;
        if (!hold_b) begin
            done = 0;
            for (int t = 0; t < 200 && !done; t++) begin
                bready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (bvalid && bready) done = 1;
                else begin @(posedge clk); #1; end
            end
            if (!done) timeout("b_handshake");
            @(posedge clk); #1;
            bready = 0;
        end
    endtask

    // mode 0: rready held high, 1: toggling 1,0,1,0..., 2: random
    task automatic axi_read(input logic [31:0] addr, input int len, input int mode, output int cycles);
        int g, beats;
        @(posedge clk); #1;
        araddr = addr; arlen = 8'(len); arvalid = 1; rready = 0;
        g = 0;
        @(negedge clk);
        while (!arready && g < 200) begin g++; @(negedge clk); end
        if (g >= 200) timeout("ar_handshake");
        @(posedge clk); #1;
        arvalid = 0;
        beats = 0; cycles = 0;
        while (beats <= len && cycles < 2000) begin
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cycles % 2) == 0) : ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (rvalid && rready) beats++;
            @(posedge clk); #1;
            cycles++;
        end
        rready = 0;
        if (beats <= len) timeout("r_beats");
    endtask

    task automatic set_beat(input int k, input logic [63:0] d, input logic [7:0] s, input logic l);
        wd[k] = d; ws[k] = s; wl[k] = l;
    endtask

    initial begin
        int st, rc;
        #2;
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bresp", bresp, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);
        #1 mon_on = 1;

        // Fill all words so every later read has a defined expectation.
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 256; k++) set_beat(k, {$urandom, $urandom}, 8'hFF, k == 255);
            axi_write(32'(blk * 2048), 255, 0, st);
        end

        // Single write/read.
        set_beat(0, 64'hDEADBEEF_01234567, 8'hFF, 1);
        axi_write(32'h10, 0, 0, st);
        chk("t1_bresp", last_bresp, 2'b00);
        chk("t1_model_pin", model[2], 64'hDEADBEEF_01234567);
        rd_log.delete();
        axi_read(32'h10, 0, 0, rc);
        chk("t1_nbeats", rd_log.size(), 1);
        chk("t1_rdata", rd_log[0], 64'hDEADBEEF_01234567);

        // Strobed burst over all-ones, read back with toggling rready.
        set_beat(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1);
        axi_write(32'h10, 0, 0, st);
        set_beat(0, 64'd1, 8'hFF, 0);
        set_beat(1, 64'd2, 8'hFF, 0);
        set_beat(2, 64'd3, 8'h0F, 0);
        set_beat(3, 64'd4, 8'hFF, 1);
        axi_write(32'h0, 3, 0, st);
        rd_log.delete();
        axi_read(32'h0, 3, 1, rc);
        chk("t2_nbeats", rd_log.size(), 4);
        chk("t2_beat0", rd_log[0], 64'd1);
        chk("t2_beat1", rd_log[1], 64'd2);
        chk("t2_beat2", rd_log[2], 64'hFFFF_FFFF_0000_0003);
        chk("t2_beat3", rd_log[3], 64'd4);

        // Index wrap at the top of the array, then out-of-range read and write.
        set_beat(0, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 0);
        set_beat(1, 64'h5A5A_0000_1111_2222, 8'hFF, 1);
        axi_write(32'((DEPTH - 1) * 8), 1, 0, st);
        chk("t3_wrap_bresp", last_bresp, 2'b00);
        rd_log.delete();
        axi_read(32'h0, 0, 0, rc);
        chk("t3_wrap_idx0", rd_log[0], 64'h5A5A_0000_1111_2222);
        rd_log.delete(); rresp_log.delete();
        axi_read(MEM_BYTES, 1, 0, rc);
        chk("t3_oor_rdata", rd_log[0], 64'd0);
        chk("t3_oor_rresp", rresp_log[1], 2'b10);
        set_beat(0, 64'h0C0C_0C0C_0C0C_0C0C, 8'hFF, 1);
        axi_write(MEM_BYTES, 0, 0, st);
        chk("t3_oor_bresp", last_bresp, 2'b10);
        rd_log.delete();
        axi_read(32'h0, 0, 0, rc);
        chk("t3_oor_unchanged", rd_log[0], 64'h5A5A_0000_1111_2222);

        // wlast early, then wlast missing on the final beat.
        set_beat(0, 64'd7, 8'hFF, 0);
        set_beat(1, 64'd8, 8'hFF, 1);
        set_beat(2, 64'd9, 8'hFF, 0);
        axi_write(32'h40, 2, 0, st);
        chk("t4_early_bresp", last_bresp, 2'b10);
        rd_log.delete();
        axi_read(32'h40, 2, 0, rc);
        chk("t4_beat2", rd_log[2], 64'd9);
        set_beat(0, 64'd5, 8'hFF, 0);
        set_beat(1, 64'd6, 8'hFF, 0);
        axi_write(32'h80, 1, 0, st);
        chk("t4_nolast_bresp", last_bresp, 2'b10);

        // Concurrent read and write to disjoint regions.
        for (int k = 0; k < 8; k++) set_beat(k, {$urandom, $urandom}, 8'hFF, k == 7);
        fork
            axi_write(32'h1000, 7, 0, st);
            axi_read(32'h800, 7, 0, rc);
        join
        chk("t5_rd_cycles", rc, 8);
        chk("t5_wr_stalls", st, 0);

        // Randomised sequential traffic, including unaligned, wrapping and out-of-range bursts.
        for (int it = 0; it < 40; it++) begin
            int len;
            logic [31:0] a;
            len = $urandom_range(0, 15);
            a = ($urandom_range(0, 9) == 0) ? MEM_BYTES + $urandom_range(0, 4095)
                                             : 32'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k <= len; k++)
                    set_beat(k, {$urandom, $urandom}, 8'($urandom),
                             (k == len) ^ ($urandom_range(0, 15) == 0));
                axi_write(a, len, 0, st);
            end else begin
                axi_read(a, len, 2, rc);
            end
        end

        // Reset in the middle of a read burst with a write response pending.
        set_beat(0, 64'h0BAD_F00D_CAFE_0001, 8'hFF, 1);
        axi_write(32'h100, 0, 1, st);
        @(posedge clk); #1;
        araddr = 32'h200; arlen = 8'd7; arvalid = 1;
        begin
            int g;
            g = 0;
            @(negedge clk);
            while (!arready && g < 200) begin g++; @(negedge clk); end
            if (g >= 200) timeout("rst_ar_handshake");
        end
        @(posedge clk); #1;
        arvalid = 0; rready = 1;
        repeat (3) @(posedge clk);
        #2;
        mon_on = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_arready", arready, 0);
        rready = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);
        mon_on = 1;
        rd_log.delete();
        axi_read(32'h100, 0, 0, rc);
        chk("post_rst_rdata", rd_log[0], 64'h0BAD_F00D_CAFE_0001);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
